registers_bank: RTL and testbench



---
 rtl/registers_bank.sv | 164 ++++++++++++++++
 tb/tb_registers_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/registers_bank.sv
// registers_bank: DEPTH x DATA_W register file behind a byte-wide strobe-framed bus.
// An access starts on a rising read/write strobe with the address on data_in; a write
// keeps sampling data_in while write is held and commits the last byte on write fall.
// A read returns the addressed byte on data_out with a one-cycle valid pulse.
// Optional build macro: REGISTERS_WR_ECHO_EN echoes each committed write on data_out/valid.

module registers_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              valid
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] WR          = 3'd1;
  localparam logic [2:0] RD          = 3'd2;
  localparam logic [2:0] WAIT_RD_LOW = 3'd3;
  localparam logic [2:0] BLOCK       = 3'd4;

  // One extra bit so DEPTH == 2**DATA_W is representable.
  localparam logic [DATA_W:0] DEPTH_W = (DATA_W + 1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, wr_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              commit;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_rise, wr_rise;
  logic              addr_in_range;
  logic [DATA_W-1:0] rd_byte;

  assign rd_rise       = read & ~rd_q;
  assign wr_rise       = write & ~wr_q;
  assign addr_in_range = ({1'b0, addr_q} < DEPTH_W);

  // Read mux: out-of-range addresses read as zero.
  always_comb begin
    rd_byte = '0;
    if (addr_in_range) begin
      rd_byte = mem[addr_q];
    end
  end

  // Access sequencer: next state, captured address/data, commit and output updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (read && write) begin
          state_d = BLOCK;
        end else if (wr_rise && !read) begin
          addr_d  = data_in;
          // A write that falls in its first WR cycle commits the address byte.
          wdata_d = data_in;
          state_d = WR;
        end else if (rd_rise && !write) begin
          addr_d  = data_in;
          state_d = RD;
        end
      end

      WR: begin
        if (read) begin
          // Colliding read aborts the write; nothing is committed.
          state_d = BLOCK;
        end else if (write) begin
          wdata_d = data_in;
        end else begin
          commit  = addr_in_range;
          state_d = IDLE;
`ifdef REGISTERS_WR_ECHO_EN
          if (addr_in_range) begin
            data_out_d = wdata_q;
            valid_d    = 1'b1;
          end
`endif
        end
      end

      RD: begin
        data_out_d = rd_byte;
        valid_d    = 1'b1;
        state_d    = WAIT_RD_LOW;
      end

      WAIT_RD_LOW: begin
        // Holding read high never repeats the access.
        if (!read) begin
          state_d = IDLE;
        end
      end

      BLOCK: begin
        if (!read && !write) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, strobe history and captured address/data.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= read;
      wr_q    <= write;
    end
  end

  // Output register: data_out holds the last result, valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  // Register array: cleared on reset, written only on a committed in-range write.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_registers_bank.sv
// Directed self-checking bench for registers_bank (default build, write echo disabled).
module tb_registers_bank;

  logic       clk = 1'b0;
  logic       nRst;
  logic       read;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid;

  int n_vec  = 0;
  int n_err  = 0;
  int vcount = 0;
  int c0;

  registers_bank #(.DATA_W(8), .DEPTH(256)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .data_in  (data_in),
    .read     (read),
    .write    (write),
    .data_out (data_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Count valid pulses away from the active edge.
  always @(negedge clk) if (valid === 1'b1) vcount++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address held for addr_cycles with write high, then data for data_cycles, then fall.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                          input int addr_cycles, input int data_cycles);
    data_in = addr;
    write   = 1'b1;
    repeat (addr_cycles) tick();
    data_in = data;
    repeat (data_cycles) tick();
    write = 1'b0;
    tick();
  endtask

  // Read held high for 5 cycles; expects exactly one valid pulse one cycle after the rise.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    int c;
    c       = vcount;
    data_in = addr;
    read    = 1'b1;
    tick();
    chk({tag, "_valid_early"}, 32'(valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp));
    repeat (3) tick();
    chk({tag, "_valid_late"}, 32'(valid), 32'd0);
    read = 1'b0;
    tick();
    tick();
    chk({tag, "_pulses"}, 32'(vcount - c), 32'd1);
    chk({tag, "_hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    nRst    = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    data_in = 8'h00;
    repeat (2) tick();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    nRst = 1'b1;

    // Idle sweep with no strobes.
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(i);
      tick();
    end
    chk("idle_pulses", 32'(vcount), 32'd0);
    chk("idle_data_out", 32'(data_out), 32'd0);

    // Both strobes together: blocked, no effect.
    read  = 1'b1;
    write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(i);
      tick();
    end
    read  = 1'b0;
    write = 1'b0;
    tick();
    chk("block_pulses", 32'(vcount), 32'd0);
    chk("block_data_out", 32'(data_out), 32'd0);
    do_read(8'h03, 8'h00, "block_rd3");
    do_read(8'h00, 8'h00, "init_rd0");
    do_read(8'hFF, 8'h00, "init_rdff");

    // Fill every register; writes must not touch data_out or valid.
    c0 = vcount;
    for (int i = 0; i < 256; i++) begin
      do_write(8'(i), 8'(8'hFF - i), 5, 5);
      tick();
    end
    chk("wr_no_pulse", 32'(vcount - c0), 32'd0);
    chk("wr_no_data_out", 32'(data_out), 32'd0);

    for (int i = 0; i < 256; i++) begin
      do_read(8'(i), 8'(8'hFF - i), "fill_rd");
    end

    // Read colliding with the data phase aborts the write.
    c0 = vcount;
    do_read(8'h01, 8'hFE, "pre_abort");
    c0      = vcount;
    data_in = 8'h10;
    write   = 1'b1;
    tick();
    data_in = 8'hA5;
    repeat (2) tick();
    read = 1'b1;
    repeat (2) tick();
    read  = 1'b0;
    write = 1'b0;
    repeat (2) tick();
    chk("abort_pulses", 32'(vcount - c0), 32'd0);
    chk("abort_data_out", 32'(data_out), 32'hFE);
    do_read(8'h10, 8'hEF, "abort_rd");

    // Write falling in the first WR cycle commits the address byte; read right after commit.
    do_write(8'h30, 8'h00, 1, 0);
    do_read(8'h30, 8'h30, "short_wr");

    // Reset in the middle of a write.
    data_in = 8'h20;
    write   = 1'b1;
    tick();
    data_in = 8'h77;
    tick();
    nRst = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    write = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
    chk("midrst_idle_valid", 32'(valid), 32'd0);
    do_read(8'h20, 8'h00, "midrst_rd20");
    do_read(8'h10, 8'h00, "midrst_rd10");
    do_write(8'h20, 8'h3C, 5, 5);
    do_read(8'h20, 8'h3C, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
